move_sync: RTL and testbench
============================

# move_sync

Lockstep move synchroniser between the link layer and the game engine. It takes the local player's direction on each game tick and asks the link layer to transmit it. It waits for the opponent's direction from the link, and only then issues a single `step` pulse carrying both directions. This keeps both boards advancing in lockstep. It sits directly downstream of the UART link block: it consumes that block's `rcvdir`, `dir2` and `start_game`, and drives its `send` input.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 50_000_000: maximum number of cycles spent in EXCHANGE before the link is declared lost.

Ports:
- `clk`  in  1  system clock; one clock domain. Reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle game-step request from the local frame timer.
- `dir_local`  in  direction  local player direction. Sampled on an accepted `tick`.
- `start_local`  in  1  local seed was sent (seed ready pulse).
- `start_remote`  in  1  remote seed fully received (link `start_game` pulse).
- `rcvdir`  in  1  one-cycle pulse: `dir_remote` is valid.
- `dir_remote`  in  direction  opponent direction from the link.
- `send`  out  1  one-cycle pulse to the link. Its rising edge transmits `dir_send`.
- `dir_send`  out  direction  direction to transmit. Connects to link `dir1`.
- `step`  out  1  one-cycle pulse: the game engine advances one move.
- `dir_p1`, `dir_p2`  out  direction  local and remote directions for the current step.
- `running`  out  1  high in WAIT_TICK or EXCHANGE.
- `link_lost`  out  1  sticky; the timeout expired.
- `desync`  out  1  sticky; the remote ran two moves ahead.

## Operation
- The FSM has four states: IDLE, WAIT_TICK, EXCHANGE, LOST. The reset state is IDLE.
- Start handling:
  - `start_local | start_remote` in any state moves the FSM to WAIT_TICK.
  - It clears the pending flag, the timeout counter, `link_lost` and `desync`.
  - It sets `dir_p1`/`dir_p2`/`dir_send` to NONE.
- `rcvdir` in WAIT_TICK:
  - The remote is one move ahead.
  - Store `dir_remote` in a one-deep buffer and set `pending`.
  - If `pending` is already set, overwrite the buffer and set `desync`.
- `tick` in WAIT_TICK:
  - Latch `dir_local` into `dir_send` and pulse `send`.
  - If `pending`, or `rcvdir` arrives in the same cycle, complete the move: pulse `step`, clear `pending`, stay in WAIT_TICK.
  - Otherwise go to EXCHANGE.
- EXCHANGE:
  - `rcvdir` completes the move: pulse `step`, set `dir_p2 = dir_remote`, return to WAIT_TICK.
  - `tick` is ignored.
  - The timeout counter increments every cycle. When it reaches `TIMEOUT_CYCLES`, go to LOST and set `link_lost`.
- IDLE and LOST:
  - `tick` and `rcvdir` are ignored.
  - `send` and `step` stay 0.
  - Only a start pulse leaves these states.
- Move completion (completing `step`):
  - `dir_p1` = latched local direction.
  - `dir_p2` = buffered or incoming remote direction.
  - NONE is passed through unchanged.
  - The timeout counter is cleared.
- Counter width: `$clog2(TIMEOUT_CYCLES+1)` bits. It saturates and never wraps.

## Timing
- All outputs are registered.
- Reset values: `send=0`, `step=0`, `running=0`, `link_lost=0`, `desync=0`. `dir_send`, `dir_p1`, `dir_p2` = NONE.
- Tick latency: a `tick` accepted in cycle N gives `send` = 1 in cycle N+1. `send` is high for exactly 1 cycle, so it is always low for at least one cycle before the next rising edge.
- Remote-completes latency: `rcvdir` in cycle M gives `step` = 1 in cycle M+1. `dir_p1`/`dir_p2` are valid from M+1 and held until the next step.
- Buffered completion: a `tick` in cycle N with `pending` set raises `send` and `step` together in N+1.
- Simultaneous events:
  - A start pulse together with `tick`/`rcvdir`: start wins, and the other inputs are dropped.
  - `tick` and `rcvdir` together in WAIT_TICK: the move completes.
- Reset mid-EXCHANGE: return to IDLE and discard the buffer. No `step` is issued.

## Configuration
- `MOVE_SYNC_TIMEOUT_EN` defined: the timeout counter and the LOST state are built.
- `MOVE_SYNC_TIMEOUT_EN` undefined:
  - No counter is built.
  - EXCHANGE waits indefinitely.
  - `link_lost` is tied to 0.
  - LOST is unreachable.

## Structure
- `snake_pkg` holds `direction` (NONE included), already shared, and the new `move_sync_state_t` enum (IDLE, WAIT_TICK, EXCHANGE, LOST).
- `snake_pkg` also holds the `MOVE_SYNC_TIMEOUT_DEFAULT` constant.
- The block is a single module with no sub-modules. The timeout counter is inline logic guarded by the macro.

## Test plan
- Reset, then `start_remote`: `running=1` one cycle later, all directions NONE, no `send`/`step`.
- Local-first exchange:
  - Stimulus: `tick` with `dir_local=UP` at cycle 10, then `rcvdir`+`LEFT` at cycle 20.
  - Response: `send` at 11 with `dir_send=UP`; `step` at 21 with `dir_p1=UP`, `dir_p2=LEFT`.
- Remote-first exchange:
  - Stimulus: `rcvdir`+`DOWN` at cycle 5, then `tick`+`RIGHT` at cycle 9.
  - Response: `send` and `step` both at 10, `dir_p2=DOWN`.
- Desync: two `rcvdir` pulses (UP, then DOWN) in WAIT_TICK, then `tick` → `desync=1`, `dir_p2=DOWN`.
- Timeout (`TIMEOUT_CYCLES=8`, macro defined): `tick`, no `rcvdir` → `link_lost=1`, `running=0` after 8 cycles in EXCHANGE. A later `rcvdir` gives no `step`. A subsequent `start_local` clears `link_lost`.
- Reset in EXCHANGE: assert `rst`, then `rcvdir` after release → no `step`, state IDLE.

Source files
------------

// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snake_pkg
// Brief    : Shared snake game types: player direction, lockstep synchroniser
//            state encoding and the default link timeout.
// Revision : 1.0 - initial release
// ============================================================================
package snake_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } direction;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    EXCHANGE  = 2'd2,
    LOST      = 2'd3
  } move_sync_state_t;

  localparam int MOVE_SYNC_TIMEOUT_DEFAULT = 50_000_000;

endpackage
`default_nettype wire

// File: rtl/move_sync.sv
`default_nettype none
// ============================================================================
// Module   : move_sync
// Brief    : Lockstep move synchroniser. Issues one step per exchanged pair of
//            local/remote directions. MOVE_SYNC_TIMEOUT_EN builds the link
//            timeout counter and the LOST state.
// Revision : 1.0 - initial release
// ============================================================================
module move_sync
  import snake_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MOVE_SYNC_TIMEOUT_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     tick,
  input  direction dir_local,
  input  logic     start_local,
  input  logic     start_remote,
  input  logic     rcvdir,
  input  direction dir_remote,
  output logic     send,
  output direction dir_send,
  output logic     step,
  output direction dir_p1,
  output direction dir_p2,
  output logic     running,
  output logic     link_lost,
  output logic     desync
);

  move_sync_state_t r_state, w_state;
  logic             r_pending, w_pending;
  direction         r_buf, w_buf;
  logic             r_send, w_send;
  logic             r_step, w_step;
  direction         r_dir_send, w_dir_send;
  direction         r_dir_p1, w_dir_p1;
  direction         r_dir_p2, w_dir_p2;
  logic             r_running;
  logic             r_desync, w_desync;

`ifdef MOVE_SYNC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_link_lost, w_link_lost;
`endif

  always_comb begin
    w_state    = r_state;
    w_pending  = r_pending;
    w_buf      = r_buf;
    w_send     = 1'b0;
    w_step     = 1'b0;
    w_dir_send = r_dir_send;
    w_dir_p1   = r_dir_p1;
    w_dir_p2   = r_dir_p2;
    w_desync   = r_desync;
`ifdef MOVE_SYNC_TIMEOUT_EN
    w_cnt       = r_cnt;
    w_link_lost = r_link_lost;
`endif

    if (start_local || start_remote) begin
      w_state    = WAIT_TICK;
      w_pending  = 1'b0;
      w_desync   = 1'b0;
      w_dir_send = NONE;
      w_dir_p1   = NONE;
      w_dir_p2   = NONE;
`ifdef MOVE_SYNC_TIMEOUT_EN
      w_cnt       = '0;
      w_link_lost = 1'b0;
`endif
    end else begin
      case (r_state)
        WAIT_TICK: begin
          if (tick) begin
            w_dir_send = dir_local;
            w_send     = 1'b1;
`ifdef MOVE_SYNC_TIMEOUT_EN
            w_cnt = '0;
`endif
            if (r_pending || rcvdir) begin
              // A remote move arriving alongside a buffered one stays buffered
              // for the next tick, so the remote remains one move ahead.
              w_step    = 1'b1;
              w_dir_p1  = dir_local;
              w_dir_p2  = r_pending ? r_buf : dir_remote;
              w_pending = r_pending && rcvdir;
              w_buf     = rcvdir ? dir_remote : r_buf;
            end else begin
              w_state = EXCHANGE;
            end
          end else if (rcvdir) begin
            w_buf     = dir_remote;
            w_pending = 1'b1;
            if (r_pending) begin
              w_desync = 1'b1;
            end
          end
        end
        EXCHANGE: begin
          if (rcvdir) begin
            w_step   = 1'b1;
            w_dir_p1 = r_dir_send;
            w_dir_p2 = dir_remote;
            w_state  = WAIT_TICK;
`ifdef MOVE_SYNC_TIMEOUT_EN
            w_cnt = '0;
`endif
          end
`ifdef MOVE_SYNC_TIMEOUT_EN
          else if (r_cnt != C_CNT_MAX) begin
            w_cnt = r_cnt + 1'b1;
            if (w_cnt == C_CNT_MAX) begin
              w_state     = LOST;
              w_link_lost = 1'b1;
            end
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pending  <= 1'b0;
      r_buf      <= NONE;
      r_send     <= 1'b0;
      r_step     <= 1'b0;
      r_dir_send <= NONE;
      r_dir_p1   <= NONE;
      r_dir_p2   <= NONE;
      r_running  <= 1'b0;
      r_desync   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_pending  <= w_pending;
      r_buf      <= w_buf;
      r_send     <= w_send;
      r_step     <= w_step;
      r_dir_send <= w_dir_send;
      r_dir_p1   <= w_dir_p1;
      r_dir_p2   <= w_dir_p2;
      r_running  <= (w_state == WAIT_TICK) || (w_state == EXCHANGE);
      r_desync   <= w_desync;
    end
  end

`ifdef MOVE_SYNC_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_link_lost <= 1'b0;
    end else begin
      r_cnt       <= w_cnt;
      r_link_lost <= w_link_lost;
    end
  end

  assign link_lost = r_link_lost;
`else
  assign link_lost = 1'b0;
`endif

  assign send     = r_send;
  assign step     = r_step;
  assign dir_send = r_dir_send;
  assign dir_p1   = r_dir_p1;
  assign dir_p2   = r_dir_p2;
  assign running  = r_running;
  assign desync   = r_desync;

endmodule
`default_nettype wire

// File: tb/tb_move_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_sync
// Brief    : Directed vector bench for move_sync (timeout expectations follow
//            MOVE_SYNC_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_move_sync;
  import snake_pkg::*;

  localparam int C_TIMEOUT = 8;
  localparam int C_NVEC    = 26;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     tick = 1'b0;
  direction dir_local = NONE;
  logic     start_local = 1'b0;
  logic     start_remote = 1'b0;
  logic     rcvdir = 1'b0;
  direction dir_remote = NONE;
  logic     send, step, running, link_lost, desync;
  direction dir_send, dir_p1, dir_p2;

  int n_checks = 0;
  int n_fail   = 0;

  move_sync #(.TIMEOUT_CYCLES(C_TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .dir_local    (dir_local),
    .start_local  (start_local),
    .start_remote (start_remote),
    .rcvdir       (rcvdir),
    .dir_remote   (dir_remote),
    .send         (send),
    .dir_send     (dir_send),
    .step         (step),
    .dir_p1       (dir_p1),
    .dir_p2       (dir_p2),
    .running      (running),
    .link_lost    (link_lost),
    .desync       (desync)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        sl;
    logic        sr;
    logic        tick;
    logic        rcv;
    direction    dl;
    direction    dr;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl [C_NVEC];

  // Output vector layout: send, step, dir_send, dir_p1, dir_p2, running, link_lost, desync
  function automatic logic [13:0] ex(logic s, logic st, direction ds, direction p1,
                                     direction p2, logic run, logic ll, logic dsy);
    return {s, st, ds, p1, p2, run, ll, dsy};
  endfunction

  function automatic logic [13:0] outs();
    return {send, step, dir_send, dir_p1, dir_p2, running, link_lost, desync};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [13:0] act, logic [13:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (send,step,ds,p1,p2,run,lost,desync)", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; start_local = 1'b0; start_remote = 1'b0;
    tick = 1'b0; rcvdir = 1'b0; dir_local = NONE; dir_remote = NONE;
  endtask

  initial begin
    logic ok;
    //          rst   sl    sr    tick  rcv   dl     dr     expected outputs
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NONE,  NONE,  ex(0,0,NONE,NONE,NONE,0,0,0)};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NONE,  NONE,  ex(0,0,NONE,NONE,NONE,0,0,0)};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, UP,    NONE,  ex(0,0,NONE,NONE,NONE,0,0,0)};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NONE,  UP,    ex(0,0,NONE,NONE,NONE,0,0,0)};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NONE,  NONE,  ex(0,0,NONE,NONE,NONE,1,0,0)};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NONE,  NONE,  ex(0,0,NONE,NONE,NONE,1,0,0)};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, UP,    NONE,  ex(1,0,UP,NONE,NONE,1,0,0)};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NONE,  NONE,  ex(0,0,UP,NONE,NONE,1,0,0)};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, DOWN,  NONE,  ex(0,0,UP,NONE,NONE,1,0,0)};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NONE,  LEFT,  ex(0,1,UP,UP,LEFT,1,0,0)};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NONE,  NONE,  ex(0,0,UP,UP,LEFT,1,0,0)};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NONE,  DOWN,  ex(0,0,UP,UP,LEFT,1,0,0)};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NONE,  NONE,  ex(0,0,UP,UP,LEFT,1,0,0)};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, RIGHT, NONE,  ex(1,1,RIGHT,RIGHT,DOWN,1,0,0)};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NONE,  NONE,  ex(0,0,RIGHT,RIGHT,DOWN,1,0,0)};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, LEFT,  UP,    ex(1,1,LEFT,LEFT,UP,1,0,0)};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NONE,  NONE,  ex(0,0,LEFT,LEFT,UP,1,0,0)};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NONE,  UP,    ex(0,0,LEFT,LEFT,UP,1,0,0)};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NONE,  DOWN,  ex(0,0,LEFT,LEFT,UP,1,0,1)};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, UP,    NONE,  ex(1,1,UP,UP,DOWN,1,0,1)};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NONE,  LEFT,  ex(0,0,UP,UP,DOWN,1,0,1)};
    tbl[21] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, RIGHT, NONE,  ex(0,0,NONE,NONE,NONE,1,0,0)};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, DOWN,  NONE,  ex(1,0,DOWN,NONE,NONE,1,0,0)};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NONE,  NONE,  ex(0,0,DOWN,NONE,NONE,1,0,0)};
    tbl[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NONE,  RIGHT, ex(0,1,DOWN,DOWN,RIGHT,1,0,0)};
    tbl[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NONE,  NONE,  ex(0,0,DOWN,DOWN,RIGHT,1,0,0)};

    #1;
    for (int i = 0; i < C_NVEC; i++) begin
      rst = tbl[i].rst; start_local = tbl[i].sl; start_remote = tbl[i].sr;
      tick = tbl[i].tick; rcvdir = tbl[i].rcv;
      dir_local = tbl[i].dl; dir_remote = tbl[i].dr;
      cyc();
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end
    idle_inputs();

    // Reset while in EXCHANGE: buffer discarded, later rcvdir ignored in IDLE.
    tick = 1'b1; dir_local = UP;
    cyc();
    idle_inputs();
    check("exch_send", outs(), ex(1,0,UP,DOWN,RIGHT,1,0,0));
    rst = 1'b1;
    cyc();
    rst = 1'b0; rcvdir = 1'b1; dir_remote = LEFT;
    cyc();
    idle_inputs();
    check("rst_exch_rcv", outs(), ex(0,0,NONE,NONE,NONE,0,0,0));
    cyc();
    check("rst_exch_idle", outs(), ex(0,0,NONE,NONE,NONE,0,0,0));

    // Timeout window: exactly C_TIMEOUT cycles in EXCHANGE.
    start_local = 1'b1;
    cyc();
    idle_inputs();
    check("to_start", outs(), ex(0,0,NONE,NONE,NONE,1,0,0));
    tick = 1'b1; dir_local = UP;
    cyc();
    idle_inputs();
    check("to_send", outs(), ex(1,0,UP,NONE,NONE,1,0,0));
    ok = 1'b1;
    for (int k = 1; k < C_TIMEOUT; k++) begin
      cyc();
      if (outs() !== ex(0,0,UP,NONE,NONE,1,0,0)) ok = 1'b0;
    end
    check("to_waiting", {13'd0, ok}, 14'd1);
    cyc();
`ifdef MOVE_SYNC_TIMEOUT_EN
    check("to_expired", outs(), ex(0,0,UP,NONE,NONE,0,1,0));
`else
    check("to_still_wait", outs(), ex(0,0,UP,NONE,NONE,1,0,0));
`endif
    rcvdir = 1'b1; dir_remote = LEFT;
    cyc();
    idle_inputs();
`ifdef MOVE_SYNC_TIMEOUT_EN
    check("lost_rcv", outs(), ex(0,0,UP,NONE,NONE,0,1,0));
`else
    check("late_rcv", outs(), ex(0,1,UP,UP,LEFT,1,0,0));
`endif
    start_local = 1'b1;
    cyc();
    idle_inputs();
    check("restart", outs(), ex(0,0,NONE,NONE,NONE,1,0,0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
